intersection_sequencer: RTL and testbench
=========================================

INTERSECTION_SEQUENCER -- requirements
Module: intersection_sequencer

Interface
REQ-001 Parameter T_GREEN_MAIN, default 30, main-road green duration in ticks; legal range 1..63.
REQ-002 Parameter T_GREEN_SIDE, default 20, side-road green duration in ticks; legal range 1..63.
REQ-003 Parameter T_YELLOW, default 3, yellow duration in ticks; legal range 1..63.
REQ-004 Parameter T_ALLRED, default 2, all-red clearance duration in ticks; legal range 1..63.
REQ-005 Parameter T_WALK, default 15, pedestrian walk duration in ticks; legal range 1..63.
REQ-006 clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 tick  in  1  one-cycle pulse from the clock divider, nominally 1 Hz; all timing advances only on tick.
REQ-009 side_req  in  1  side-road vehicle sensor, level or pulse.
REQ-010 ped_req  in  1  pedestrian push-button, level or pulse.
REQ-011 night  in  1  night-mode request; the block flashes yellow while this is active.
REQ-012 main_light  out  2  main-road lamp: 0 red, 1 yellow, 2 green, 3 off.
REQ-013 side_light  out  2  side-road lamp, same encoding as main_light.
REQ-014 walk  out  1  pedestrian walk lamp.
REQ-015 time_left  out  6  remaining ticks in the current phase, binary, for the two-digit display.
REQ-016 phase  out  3  current FSM state code, for debug.

Function
REQ-017 The FSM SHALL have eight states: MAIN_GREEN, MAIN_YELLOW, ALLRED1, SIDE_GREEN, SIDE_YELLOW, ALLRED2, PED_WALK and FLASH.
REQ-018 Lamp outputs per state SHALL be as follows.
- MAIN_GREEN: main green, side red.
- MAIN_YELLOW: main yellow, side red.
- SIDE_GREEN: main red, side green.
- SIDE_YELLOW: main red, side yellow.
- ALLRED1, ALLRED2, PED_WALK: both red.
- walk is 1 only in PED_WALK.
REQ-019 On entry to a timed state, time_left SHALL load that state's duration parameter.
REQ-020 On each tick with time_left>1, time_left SHALL decrement by 1; ticks never change it otherwise.
REQ-021 A tick with time_left==1 SHALL be an expiry; on expiry the state SHALL change in the same edge and time_left SHALL load the new state's duration.
REQ-022 At MAIN_GREEN expiry, the next state depends on pending requests.
- side_pending or ped_pending set: go to MAIN_YELLOW.
- Neither set: stay in MAIN_GREEN and reload T_GREEN_MAIN.
REQ-023 MAIN_YELLOW SHALL go to ALLRED1 on expiry.
REQ-024 At ALLRED1 expiry: go to SIDE_GREEN if side_pending, else PED_WALK.
REQ-025 SIDE_GREEN SHALL go to SIDE_YELLOW on expiry, and SIDE_YELLOW SHALL go to ALLRED2 on expiry.
REQ-026 At ALLRED2 expiry: go to PED_WALK if ped_pending, else MAIN_GREEN.
REQ-027 PED_WALK SHALL go to MAIN_GREEN on expiry.
REQ-028 side_pending SHALL set in any cycle side_req=1 and SHALL clear on entry to SIDE_GREEN.
- If a set and a clear fall in the same cycle, the clear wins.
REQ-029 ped_pending SHALL set in any cycle ped_req=1 and SHALL clear on entry to PED_WALK.
- If a set and a clear fall in the same cycle, the clear wins.
REQ-030 A tick with night=1 in any non-FLASH state SHALL enter FLASH.
- Entry is immediate; the running phase is abandoned.
- Pending flags are retained.
REQ-031 In FLASH the block SHALL behave as follows.
- time_left is 0.
- walk is 0.
- main_light and side_light both alternate between yellow and off, toggling on each tick.
- The first tick after entry shows yellow.
REQ-032 A tick with night=0 in FLASH SHALL go to ALLRED2 and load T_ALLRED.
REQ-033 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-034 A tick arriving in the same cycle as reset SHALL be ignored.

Reset
REQ-035 When reset=1 at a clock edge, the block SHALL return to its start-up values on that edge regardless of state.
- state = MAIN_GREEN; time_left = T_GREEN_MAIN.
- main_light = 2; side_light = 0; walk = 0.
- side_pending = 0; ped_pending = 0; the flash toggle is 0.
REQ-036 The first tick after reset releases SHALL decrement time_left to T_GREEN_MAIN-1.

Structure
REQ-037 The shared package tl_pkg SHALL hold the following.
- The state enumeration and its 3-bit codes.
- The lamp encoding constants RED, YELLOW, GREEN and OFF.
- The default duration constants.
REQ-038 Request latching SHALL be a sub-module tl_req_latch (set, clear, pending, with clear priority), instantiated twice.
REQ-039 The FSM, the duration counter and the flash toggle SHALL live in intersection_sequencer.
- Expected size is 150-300 lines of RTL.

Verification
REQ-040 Idle recycling: reset, no requests, 30 ticks -> state stays MAIN_GREEN and time_left reloads 30 after reaching 1.
REQ-041 Side cycle: side_req pulse during MAIN_GREEN -> states follow each other with these durations.
- MAIN_YELLOW, 3 ticks.
- ALLRED1, 2 ticks.
- SIDE_GREEN, 20 ticks.
- SIDE_YELLOW, 3 ticks.
- ALLRED2, 2 ticks.
- Then back to MAIN_GREEN.
REQ-042 Pedestrian only: ped_req pulse -> sequence is MAIN_YELLOW, ALLRED1, PED_WALK, MAIN_GREEN.
- walk=1 for exactly 15 ticks.
- SIDE_GREEN is never entered.
REQ-043 Both requests: side_req and ped_req together -> SIDE_GREEN, then ALLRED2, then PED_WALK.
- Each flag clears on entry to its own state.
REQ-044 Clear-priority race: side_req held high across the SIDE_GREEN entry edge and then dropped -> side_pending=0 after that entry.
REQ-045 Night mode and mid-run reset: night=1 at a tick mid SIDE_GREEN -> FLASH, both lamps go yellow/off/yellow on successive ticks.
- night=0 -> ALLRED2 with time_left=2.
- reset asserted mid PED_WALK -> MAIN_GREEN with time_left=30 on the next edge.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared definitions for the intersection sequencer: state codes,
// lamp encoding and default phase durations (in ticks).
package tl_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALLRED1     = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALLRED2     = 3'd5,
        PED_WALK    = 3'd6,
        FLASH       = 3'd7
    } state_t;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;
    localparam logic [1:0] OFF    = 2'd3;

    localparam int DEF_T_GREEN_MAIN = 30;
    localparam int DEF_T_GREEN_SIDE = 20;
    localparam int DEF_T_YELLOW     = 3;
    localparam int DEF_T_ALLRED     = 2;
    localparam int DEF_T_WALK       = 15;

endpackage

// File: rtl/tl_req_latch.sv
// Sticky request flag: sets on any cycle with set=1, clears on clear=1.
// A clear in the same cycle as a set wins.
module tl_req_latch (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clear,
    output logic pending
);

    // Pending flag register with clear priority over set
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (set) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/intersection_sequencer.sv
// Traffic-light sequencer for a main/side road crossing with a pedestrian
// phase and a night-time flashing-yellow mode. Timing advances only on tick.
module intersection_sequencer
    import tl_pkg::*;
#(
    parameter int T_GREEN_MAIN = DEF_T_GREEN_MAIN,
    parameter int T_GREEN_SIDE = DEF_T_GREEN_SIDE,
    parameter int T_YELLOW     = DEF_T_YELLOW,
    parameter int T_ALLRED     = DEF_T_ALLRED,
    parameter int T_WALK       = DEF_T_WALK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       night,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic       walk,
    output logic [5:0] time_left,
    output logic [2:0] phase
);

    state_t     state, next_state;
    logic [5:0] next_time;
    logic       flash_on, next_flash;
    logic [1:0] next_main, next_side;
    logic       next_walk;
    logic       side_pending, ped_pending;
    logic       side_clr, ped_clr;

    function automatic logic [5:0] dur_of(state_t s);
        case (s)
            MAIN_GREEN:               return 6'(T_GREEN_MAIN);
            MAIN_YELLOW, SIDE_YELLOW: return 6'(T_YELLOW);
            ALLRED1, ALLRED2:         return 6'(T_ALLRED);
            SIDE_GREEN:               return 6'(T_GREEN_SIDE);
            PED_WALK:                 return 6'(T_WALK);
            default:                  return '0;
        endcase
    endfunction

    tl_req_latch u_side_latch (
        .clk     (clk),
        .reset   (reset),
        .set     (side_req),
        .clear   (side_clr),
        .pending (side_pending)
    );

    tl_req_latch u_ped_latch (
        .clk     (clk),
        .reset   (reset),
        .set     (ped_req),
        .clear   (ped_clr),
        .pending (ped_pending)
    );

    // Next state, duration counter and flash toggle; night overrides expiry
    always_comb begin
        next_state = state;
        next_time  = time_left;
        next_flash = flash_on;
        if (tick) begin
            if (state == FLASH) begin
                if (night) begin
                    next_flash = ~flash_on;
                end else begin
                    next_state = ALLRED2;
                    next_time  = dur_of(ALLRED2);
                    next_flash = 1'b0;
                end
            end else if (night) begin
                next_state = FLASH;
                next_time  = '0;
                next_flash = 1'b0;
            end else if (time_left > 6'd1) begin
                next_time = time_left - 6'd1;
            end else begin
                case (state)
                    MAIN_GREEN:  next_state = (side_pending || ped_pending) ? MAIN_YELLOW : MAIN_GREEN;
                    MAIN_YELLOW: next_state = ALLRED1;
                    ALLRED1:     next_state = side_pending ? SIDE_GREEN : PED_WALK;
                    SIDE_GREEN:  next_state = SIDE_YELLOW;
                    SIDE_YELLOW: next_state = ALLRED2;
                    ALLRED2:     next_state = ped_pending ? PED_WALK : MAIN_GREEN;
                    PED_WALK:    next_state = MAIN_GREEN;
                    default:     next_state = state;
                endcase
                next_time = dur_of(next_state);
            end
        end
    end

    // Lamp decode of the upcoming state and request clears on phase entry
    always_comb begin
        next_main = RED;
        next_side = RED;
        next_walk = 1'b0;
        case (next_state)
            MAIN_GREEN:  next_main = GREEN;
            MAIN_YELLOW: next_main = YELLOW;
            SIDE_GREEN:  next_side = GREEN;
            SIDE_YELLOW: next_side = YELLOW;
            PED_WALK:    next_walk = 1'b1;
            FLASH: begin
                next_main = next_flash ? YELLOW : OFF;
                next_side = next_flash ? YELLOW : OFF;
            end
            default: ;
        endcase
        side_clr = (next_state == SIDE_GREEN) && (state != SIDE_GREEN);
        ped_clr  = (next_state == PED_WALK) && (state != PED_WALK);
    end

    // State and output registers; reset outranks a coincident tick
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= MAIN_GREEN;
            time_left  <= dur_of(MAIN_GREEN);
            flash_on   <= 1'b0;
            main_light <= GREEN;
            side_light <= RED;
            walk       <= 1'b0;
        end else begin
            state      <= next_state;
            time_left  <= next_time;
            flash_on   <= next_flash;
            main_light <= next_main;
            side_light <= next_side;
            walk       <= next_walk;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Bench for intersection_sequencer: directed scenarios plus random stimulus,
// every cycle compared against a table-driven phase model.
module tb_intersection_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       night = 1'b0;
    logic [1:0] main_light;
    logic [1:0] side_light;
    logic       walk;
    logic [5:0] time_left;
    logic [2:0] phase;

    int n_vec = 0;
    int n_err = 0;
    int n_cyc = 0;

    // phase numbers in the order the eight states are listed
    localparam int P_MG = 0, P_MY = 1, P_AR1 = 2, P_SG = 3;
    localparam int P_SY = 4, P_AR2 = 5, P_PW = 6, P_FL = 7;

    int dur_tab  [8] = '{30, 3, 2, 20, 3, 2, 15, 0};
    int main_tab [8] = '{2, 1, 0, 0, 0, 0, 0, 0};
    int side_tab [8] = '{0, 0, 0, 2, 1, 0, 0, 0};

    int m_ph, m_left;
    bit m_side, m_ped, m_fl;

    intersection_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .night      (night),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .time_left  (time_left),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, n_cyc);
        end
    endtask

    function automatic int successor(int ph, bit sp, bit pp);
        case (ph)
            P_MG:    return (sp || pp) ? P_MY : P_MG;
            P_MY:    return P_AR1;
            P_AR1:   return sp ? P_SG : P_PW;
            P_SG:    return P_SY;
            P_SY:    return P_AR2;
            P_AR2:   return pp ? P_PW : P_MG;
            default: return P_MG;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit t, input bit s, input bit p, input bit n);
        int prev;
        if (r) begin
            m_ph = P_MG; m_left = dur_tab[P_MG];
            m_side = 0; m_ped = 0; m_fl = 0;
            return;
        end
        prev = m_ph;
        if (t) begin
            if (m_ph == P_FL) begin
                if (n) m_fl = !m_fl;
                else begin m_ph = P_AR2; m_left = dur_tab[P_AR2]; end
            end else if (n) begin
                m_ph = P_FL; m_left = 0; m_fl = 0;
            end else if (m_left > 1) begin
                m_left = m_left - 1;
            end else begin
                m_ph = successor(m_ph, m_side, m_ped);
                m_left = dur_tab[m_ph];
            end
        end
        m_side = (m_ph == P_SG && prev != P_SG) ? 1'b0 : (m_side | s);
        m_ped  = (m_ph == P_PW && prev != P_PW) ? 1'b0 : (m_ped | p);
    endtask

    task automatic cycle(input bit r, input bit t, input bit s, input bit p, input bit n);
        int em, es;
        @(negedge clk);
        reset = r; tick = t; side_req = s; ped_req = p; night = n;
        model_step(r, t, s, p, n);
        @(posedge clk);
        #1;
        n_cyc++;
        if (m_ph == P_FL) begin
            em = m_fl ? 1 : 3;
            es = em;
        end else begin
            em = main_tab[m_ph];
            es = side_tab[m_ph];
        end
        check_eq("main_light", int'(main_light), em);
        check_eq("side_light", int'(side_light), es);
        check_eq("walk",       int'(walk),       (m_ph == P_PW) ? 1 : 0);
        check_eq("time_left",  int'(time_left),  m_left);
        check_eq("phase",      int'(phase),      m_ph);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0);
    endtask

    initial begin
        bit nt;
        m_ph = P_MG; m_left = 30; m_side = 0; m_ped = 0; m_fl = 0;

        // reset, then idle recycling of main green
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        run_ticks(35);

        // side request cycle
        cycle(0, 0, 1, 0, 0);
        run_ticks(40);

        // pedestrian only
        cycle(0, 0, 0, 1, 0);
        run_ticks(70);

        // both requests
        cycle(0, 1, 1, 1, 0);
        run_ticks(90);

        // side_req held across side-green entry, then dropped
        for (int i = 0; i < 200 && m_ph != P_SG; i++) cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        run_ticks(70);

        // night mode mid side green, then back out
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 200 && m_ph != P_SG; i++) cycle(0, 1, 0, 0, 0);
        run_ticks(5);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 0, 1);
            cycle(0, 0, 0, 0, 1);
        end
        cycle(0, 1, 0, 0, 0);
        run_ticks(10);

        // reset (with a coincident tick) mid pedestrian walk
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 200 && m_ph != P_PW; i++) cycle(0, 1, 0, 0, 0);
        run_ticks(4);
        cycle(1, 1, 0, 0, 0);
        run_ticks(3);

        // random traffic
        nt = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) nt = !nt;
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 39) == 0,
                  nt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
